enemy_jump_ctrl: RTL and testbench

ENEMY_JUMP_CTRL -- requirements
Module: enemy_jump_ctrl

---
 rtl/enemy_pkg.sv | 20 ++
 rtl/enemy_jump_ctrl_if.sv | 27 ++
 rtl/edge_window_cmp.sv | 31 +++
 rtl/enemy_jump_ctrl.sv | 102 ++++++++++
 tb/tb_enemy_jump_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/enemy_pkg.sv
// Shared types for the enemy jump controller: travel direction, FSM states,
// and the default location width.
package enemy_pkg;

    localparam int LOC_W_DEF = 14;

    typedef enum logic [1:0] {
        DIR_STILL = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_JUMP = 2'b10,
        ST_AIR  = 2'b11
    } state_t;

endpackage

// File: rtl/enemy_jump_ctrl_if.sv
// Bundles the frame/enemy/platform inputs and jump status outputs of the
// enemy jump controller.
interface enemy_jump_ctrl_if import enemy_pkg::*; #(
    parameter int LOC_W    = LOC_W_DEF,
    parameter int NUM_PLAT = 16,
    parameter int IDX_W    = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
);
    logic                           frame_tick;
    logic [LOC_W-1:0]               enemy_loc;
    logic [1:0]                     enemy_dir;
    logic [NUM_PLAT-1:0][LOC_W-1:0] plat_edge;
    logic [NUM_PLAT-1:0]            plat_valid;
    logic                           jump;
    logic                           airborne;
    logic                           busy;
    logic [IDX_W-1:0]               hit_idx;

    modport master (
        output frame_tick, enemy_loc, enemy_dir, plat_edge, plat_valid,
        input  jump, airborne, busy, hit_idx
    );

    modport slave (
        input  frame_tick, enemy_loc, enemy_dir, plat_edge, plat_valid,
        output jump, airborne, busy, hit_idx
    );
endinterface

// File: rtl/edge_window_cmp.sv
// Decides whether one platform edge lies within the look-ahead window in
// front of the enemy; differences are taken one bit wider so nothing wraps.
module edge_window_cmp import enemy_pkg::*; #(
    parameter int LOC_W     = LOC_W_DEF,
    parameter int LOOKAHEAD = 5
) (
    input  logic [LOC_W-1:0] i_loc,
    input  logic [LOC_W-1:0] i_edge,
    input  logic             i_valid,
    input  dir_t             i_dir,
    output logic             o_hit
);
    localparam int WB = LOC_W + 1;
    localparam logic [LOC_W:0] WIN_MAX = WB'(LOOKAHEAD - 1);

    logic [LOC_W:0] w_fwd;
    logic [LOC_W:0] w_bwd;

    // MSB set means the edge sits behind the enemy for that direction.
    assign w_fwd = {1'b0, i_edge} - {1'b0, i_loc};
    assign w_bwd = {1'b0, i_loc} - {1'b0, i_edge};

    always_comb begin
        o_hit = 1'b0;
        case (i_dir)
            DIR_RIGHT: o_hit = i_valid && !w_fwd[LOC_W] && (w_fwd <= WIN_MAX);
            DIR_LEFT:  o_hit = i_valid && !w_bwd[LOC_W] && (w_bwd <= WIN_MAX);
            default:   o_hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/enemy_jump_ctrl.sv
// Per-frame platform-edge scan for a moving enemy: one table entry per cycle,
// first hit triggers a jump pulse followed by an airborne period in frames.
module enemy_jump_ctrl import enemy_pkg::*; #(
    parameter int LOC_W      = LOC_W_DEF,
    parameter int NUM_PLAT   = 16,
    parameter int LOOKAHEAD  = 5,
    parameter int AIR_FRAMES = 32
) (
    input logic              Clk,
    input logic              Reset_n,
    enemy_jump_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W-1:0] r_hit_idx, w_hit_idx_nxt;
    logic [LOC_W-1:0] r_loc, w_loc_nxt;
    dir_t             r_dir, w_dir_nxt;
    logic [7:0]       r_air_cnt, w_air_cnt_nxt;
    logic [LOC_W-1:0] w_edge;
    logic             w_valid;
    logic             w_hit;
    logic             w_start;

    assign w_edge  = bus.plat_edge[r_idx];
    assign w_valid = bus.plat_valid[r_idx];
    assign w_start = bus.frame_tick &&
                     (bus.enemy_dir == DIR_RIGHT || bus.enemy_dir == DIR_LEFT);

    edge_window_cmp #(.LOC_W(LOC_W), .LOOKAHEAD(LOOKAHEAD)) u_cmp (
        .i_loc   (r_loc),
        .i_edge  (w_edge),
        .i_valid (w_valid),
        .i_dir   (r_dir),
        .o_hit   (w_hit)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_hit_idx <= '0;
            r_loc     <= '0;
            r_dir     <= DIR_STILL;
            r_air_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_hit_idx <= w_hit_idx_nxt;
            r_loc     <= w_loc_nxt;
            r_dir     <= w_dir_nxt;
            r_air_cnt <= w_air_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_hit_idx_nxt = r_hit_idx;
        w_loc_nxt     = r_loc;
        w_dir_nxt     = r_dir;
        w_air_cnt_nxt = r_air_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_loc_nxt   = bus.enemy_loc;
                    w_dir_nxt   = dir_t'(bus.enemy_dir);
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_hit_idx_nxt = r_idx;
                    w_state_nxt   = ST_JUMP;
                end else if (r_idx == IDX_W'(NUM_PLAT - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            ST_JUMP: begin
                w_air_cnt_nxt = 8'(AIR_FRAMES);
                w_state_nxt   = ST_AIR;
            end
            ST_AIR: begin
                // Ticks only count down the flight; they never start a scan here.
                if (bus.frame_tick) begin
                    w_air_cnt_nxt = r_air_cnt - 8'd1;
                    if (r_air_cnt == 8'd1) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.jump     = (r_state == ST_JUMP);
    assign bus.airborne = (r_state == ST_AIR);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.hit_idx  = r_hit_idx;
endmodule

// File: tb/tb_enemy_jump_ctrl.sv
// Directed bench for enemy_jump_ctrl: hand-computed latencies, window edges,
// no-wrap misses, priority, airborne duration and mid-scan reset.
module tb_enemy_jump_ctrl;
    import enemy_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_jumps;

    enemy_jump_ctrl_if #(.LOC_W(14), .NUM_PLAT(16)) bus ();

    enemy_jump_ctrl #(
        .LOC_W(14), .NUM_PLAT(16), .LOOKAHEAD(5), .AIR_FRAMES(32)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.jump === 1'b1) n_jumps <= n_jumps + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick asserted in cycle 0; returns in cycle 1 with the tick dropped.
    task automatic pulse_tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic finish_air();
        repeat (32) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_jumps = 0;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.enemy_loc  = '0;
        bus.enemy_dir  = 2'b00;
        bus.plat_edge  = '0;
        bus.plat_valid = '0;
        step(); step();
        chk("rst_jump",     32'(bus.jump),     0);
        chk("rst_airborne", 32'(bus.airborne), 0);
        chk("rst_busy",     32'(bus.busy),     0);
        chk("rst_hit_idx",  32'(bus.hit_idx),  0);
        rst_n = 1'b1;
        step();

        // Right hit at entry 0, then full airborne period with ticks and dir changes.
        bus.plat_edge[0] = 14'd104;
        bus.plat_valid   = 16'h0001;
        bus.enemy_loc    = 14'd100;
        bus.enemy_dir    = 2'b01;
        pulse_tick();
        chk("a_c1_busy", 32'(bus.busy), 1);
        chk("a_c1_jump", 32'(bus.jump), 0);
        step();
        chk("a_c2_jump",     32'(bus.jump),     1);
        chk("a_c2_hit_idx",  32'(bus.hit_idx),  0);
        chk("a_c2_airborne", 32'(bus.airborne), 0);
        step();
        chk("a_c3_jump",     32'(bus.jump),     0);
        chk("a_c3_airborne", 32'(bus.airborne), 1);
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                bus.enemy_dir = 2'b10;
                bus.enemy_loc = 14'd104;
            end
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            if (i == 31) chk("a_air_31", 32'(bus.airborne), 1);
            if (i == 32) begin
                chk("a_air_32",  32'(bus.airborne), 0);
                chk("a_busy_32", 32'(bus.busy),     0);
            end
            step();
        end
        chk("a_jumps", 32'(n_jumps), 1);

        // Right edge at distance 5: outside window, full 16-entry scan.
        bus.plat_edge    = '0;
        bus.plat_edge[3] = 14'd105;
        bus.plat_valid   = 16'h0008;
        bus.enemy_loc    = 14'd100;
        bus.enemy_dir    = 2'b01;
        pulse_tick();
        repeat (15) step();
        chk("b_c16_busy", 32'(bus.busy), 1);
        step();
        chk("b_c17_busy", 32'(bus.busy),    0);
        chk("b_jumps",    32'(n_jumps),     1);
        chk("b_hit_hold", 32'(bus.hit_idx), 0);

        // Left edge at distance 4 at entry 3; inputs change mid-scan.
        bus.plat_edge[3] = 14'd96;
        bus.enemy_dir    = 2'b10;
        pulse_tick();
        step();
        bus.enemy_loc = 14'd0;
        bus.enemy_dir = 2'b01;
        step(); step();
        chk("c_c4_jump", 32'(bus.jump), 0);
        step();
        chk("c_c5_jump",    32'(bus.jump),    1);
        chk("c_c5_hit_idx", 32'(bus.hit_idx), 3);
        step();
        finish_air();
        chk("c_jumps", 32'(n_jumps), 2);

        // Left scan from loc 2 must not wrap onto edge 16380.
        bus.plat_edge    = '0;
        bus.plat_edge[0] = 14'd16380;
        bus.plat_valid   = 16'h0001;
        bus.enemy_loc    = 14'd2;
        bus.enemy_dir    = 2'b10;
        pulse_tick();
        repeat (16) step();
        chk("d_busy",     32'(bus.busy),    0);
        chk("d_jumps",    32'(n_jumps),     2);
        chk("d_hit_hold", 32'(bus.hit_idx), 3);

        // Two hits: lower index wins.
        bus.plat_edge    = '0;
        bus.plat_edge[2] = 14'd101;
        bus.plat_edge[7] = 14'd102;
        bus.plat_valid   = 16'h0084;
        bus.enemy_loc    = 14'd100;
        bus.enemy_dir    = 2'b01;
        pulse_tick();
        step(); step();
        chk("e_c3_jump", 32'(bus.jump), 0);
        step();
        chk("e_c4_jump",    32'(bus.jump),    1);
        chk("e_c4_hit_idx", 32'(bus.hit_idx), 2);
        step();
        finish_air();
        chk("e_jumps", 32'(n_jumps), 3);

        // Still / 11 directions never start a scan.
        bus.enemy_dir = 2'b00;
        pulse_tick();
        chk("g_dir00_busy", 32'(bus.busy), 0);
        bus.enemy_dir = 2'b11;
        pulse_tick();
        chk("g_dir11_busy", 32'(bus.busy), 0);

        // Reset in scan cycle 3 with the hit pending at entry 5.
        bus.plat_edge    = '0;
        bus.plat_edge[5] = 14'd100;
        bus.plat_valid   = 16'h0020;
        bus.enemy_loc    = 14'd100;
        bus.enemy_dir    = 2'b01;
        pulse_tick();
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("f_rst_jump",     32'(bus.jump),     0);
        chk("f_rst_airborne", 32'(bus.airborne), 0);
        chk("f_rst_busy",     32'(bus.busy),     0);
        chk("f_rst_hit_idx",  32'(bus.hit_idx),  0);
        step(); step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("f_idle_busy", 32'(bus.busy), 0);
        chk("f_jumps",     32'(n_jumps),  3);
        pulse_tick();
        repeat (5) step();
        chk("f_c6_jump", 32'(bus.jump), 0);
        step();
        chk("f_c7_jump",    32'(bus.jump),    1);
        chk("f_c7_hit_idx", 32'(bus.hit_idx), 5);
        step();
        finish_air();
        chk("f_jumps_end", 32'(n_jumps), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
